ex_mem_buffer: RTL and testbench

EX/MEM pipeline stage sitting directly downstream of the ALU: it registers the ALU result, zero flag and the control/data fields that travel with the instruction, and resolves the branch condition for BEQ (SUB, ALUCtl 110) and BGTZ (ALUCtl 100). A two-entry skid buffer with valid/ready handshakes on both sides lets the memory stage stall without a combinational ready path back into EX. A synchronous flush discards all in-flight entries on a mispredict or exception.

---
 rtl/ex_mem_buffer.sv | 135 +++++++++++++
 tb/tb_ex_mem_buffer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_buffer.sv
// EX/MEM stage: two-entry skid buffer registering ALU result, control fields and resolved branch decision.
// Latency 1 cycle when empty; in_ready is a flop so out_ready has no combinational path back to EX.
`timescale 1ns/1ps
module ex_mem_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] Res_in,
  input  logic              ZF_in,
  input  logic [2:0]        ALUCtl_in,
  input  logic              Branch_in,
  input  logic [DATA_W-1:0] PCBranch_in,
  input  logic [DATA_W-1:0] StoreData_in,
  input  logic [REG_W-1:0]  WriteReg_in,
  input  logic              RegWrite_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              MemToReg_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Res_out,
  output logic              ZF_out,
  output logic [DATA_W-1:0] PCBranch_out,
  output logic [DATA_W-1:0] StoreData_out,
  output logic [REG_W-1:0]  WriteReg_out,
  output logic              RegWrite_out,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic              MemToReg_out,
  output logic              BranchTaken_out,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              zf;
    logic [DATA_W-1:0] pcb;
    logic [DATA_W-1:0] sd;
    logic [REG_W-1:0]  wr;
    logic              rw;
    logic              mr;
    logic              mw;
    logic              m2r;
    logic              taken;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, MAIN = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_nx;
  entry_t main_q, skid_q, in_ent;
  logic   acc, xfer, load_main, load_skid, main_from_skid;

  // Branch decision resolved at accept so it travels with the entry.
  assign in_ent.res   = Res_in;
  assign in_ent.zf    = ZF_in;
  assign in_ent.pcb   = PCBranch_in;
  assign in_ent.sd    = StoreData_in;
  assign in_ent.wr    = WriteReg_in;
  assign in_ent.rw    = RegWrite_in;
  assign in_ent.mr    = MemRead_in;
  assign in_ent.mw    = MemWrite_in;
  assign in_ent.m2r   = MemToReg_in;
  assign in_ent.taken = Branch_in && ((ALUCtl_in == 3'b110 && ZF_in) ||
                                      (ALUCtl_in == 3'b100 && !ZF_in));

  assign out_valid = (state != EMPTY);
  assign acc       = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_nx       = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: if (acc) begin
        state_nx  = MAIN;
        load_main = 1'b1;
      end
      MAIN: begin
        if (acc && xfer) begin
          load_main = 1'b1;
        end else if (acc) begin
          state_nx  = FULL;
          load_skid = 1'b1;
        end else if (xfer) begin
          state_nx = EMPTY;
        end
      end
      FULL: if (xfer) begin
        state_nx       = MAIN;
        main_from_skid = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      // Only the taken flag is cleared; stale data behind out_valid=0 is harmless.
      state        <= EMPTY;
      in_ready     <= 1'b1;
      main_q.taken <= 1'b0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != FULL);
      if (load_main)      main_q <= in_ent;
      if (main_from_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_ent;
    end
  end

  assign Res_out         = main_q.res;
  assign ZF_out          = main_q.zf;
  assign PCBranch_out    = main_q.pcb;
  assign StoreData_out   = main_q.sd;
  assign WriteReg_out    = main_q.wr;
  assign RegWrite_out    = main_q.rw;
  assign MemRead_out     = main_q.mr;
  assign MemWrite_out    = main_q.mw;
  assign MemToReg_out    = main_q.m2r;
  assign BranchTaken_out = main_q.taken;
  assign occupancy       = state;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Directed table-driven bench for ex_mem_buffer plus hand sequences for stall and reset corners.
`timescale 1ns/1ps
module tb_ex_mem_buffer;
  localparam logic [31:0] SDK = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, ZF_in, Branch_in, flush, out_valid, out_ready;
  logic [31:0] Res_in, PCBranch_in, StoreData_in, Res_out, PCBranch_out, StoreData_out;
  logic [2:0]  ALUCtl_in;
  logic [4:0]  WriteReg_in, WriteReg_out;
  logic        RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in;
  logic        ZF_out, RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out, BranchTaken_out;
  logic [1:0]  occupancy;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_mem_buffer #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Res_in(Res_in), .ZF_in(ZF_in), .ALUCtl_in(ALUCtl_in), .Branch_in(Branch_in),
    .PCBranch_in(PCBranch_in), .StoreData_in(StoreData_in), .WriteReg_in(WriteReg_in),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemToReg_in(MemToReg_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .Res_out(Res_out), .ZF_out(ZF_out), .PCBranch_out(PCBranch_out),
    .StoreData_out(StoreData_out), .WriteReg_out(WriteReg_out), .RegWrite_out(RegWrite_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .MemToReg_out(MemToReg_out),
    .BranchTaken_out(BranchTaken_out), .occupancy(occupancy)
  );

  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] res;
    logic        zf;
    logic [2:0]  alu;
    logic        br;
    logic [31:0] pcb;
    logic        ordy;
    logic        ov, ir;
    logic [1:0]  occ;
    logic [1:0]  chk;   // [0]: data fields, [1]: branch-taken only
    logic [31:0] reso;
    logic        zfo, tko;
    logic [31:0] pcbo;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] res, logic zf,
                              logic [2:0] alu, logic br, logic [31:0] pcb, logic ordy,
                              logic ov, logic ir, logic [1:0] occ, logic [1:0] chk,
                              logic [31:0] reso, logic zfo, logic tko, logic [31:0] pcbo);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.res = res; v.zf = zf; v.alu = alu; v.br = br;
    v.pcb = pcb; v.ordy = ordy; v.ov = ov; v.ir = ir; v.occ = occ; v.chk = chk;
    v.reso = reso; v.zfo = zfo; v.tko = tko; v.pcbo = pcbo;
    return v;
  endfunction

  task automatic drive(logic r, logic f, logic iv, logic [31:0] res, logic zf,
                       logic [2:0] alu, logic br, logic [31:0] pcb, logic ordy);
    rst = r; flush = f; in_valid = iv; Res_in = res; ZF_in = zf; ALUCtl_in = alu;
    Branch_in = br; PCBranch_in = pcb; out_ready = ordy;
    StoreData_in = res ^ SDK; WriteReg_in = res[4:0];
    RegWrite_in = res[0]; MemRead_in = res[1]; MemWrite_in = res[2]; MemToReg_in = res[3];
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 3'b010, 1'b0, 32'd0, 1'b0);
    //            rst f  iv res    zf alu     br pcb    or   ov ir occ chk   reso   zfo tko pcbo
    vecs[0]  = mk(1, 0, 0, 0,     0, 3'b010, 0, 0,     0,   0, 1, 0, 2'b01, 0,     0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 11,    0, 3'b010, 0, 0,     1,   1, 1, 1, 2'b01, 11,    0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 12,    0, 3'b010, 0, 0,     1,   1, 1, 1, 2'b01, 12,    0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 13,    0, 3'b010, 0, 0,     1,   1, 1, 1, 2'b01, 13,    0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0,     0, 3'b010, 0, 0,     1,   0, 1, 0, 2'b00, 0,     0, 0, 0);
    vecs[5]  = mk(0, 0, 1, 0,     1, 3'b110, 1, 'h40,  1,   1, 1, 1, 2'b01, 0,     1, 1, 'h40);
    vecs[6]  = mk(0, 0, 1, 5,     0, 3'b110, 1, 'h40,  1,   1, 1, 1, 2'b01, 5,     0, 0, 'h40);
    vecs[7]  = mk(0, 0, 1, 7,     0, 3'b100, 1, 'h80,  1,   1, 1, 1, 2'b01, 7,     0, 1, 'h80);
    vecs[8]  = mk(0, 0, 1, 0,     1, 3'b100, 1, 'h80,  1,   1, 1, 1, 2'b01, 0,     1, 0, 'h80);
    vecs[9]  = mk(0, 0, 1, 0,     1, 3'b000, 1, 'hC0,  1,   1, 1, 1, 2'b01, 0,     1, 0, 'hC0);
    vecs[10] = mk(0, 0, 1, 0,     1, 3'b110, 0, 'hC4,  1,   1, 1, 1, 2'b01, 0,     1, 0, 'hC4);
    vecs[11] = mk(0, 0, 0, 0,     0, 3'b010, 0, 0,     1,   0, 1, 0, 2'b00, 0,     0, 0, 0);
    vecs[12] = mk(0, 0, 1, 3,     0, 3'b010, 0, 'h10,  0,   1, 1, 1, 2'b01, 3,     0, 0, 'h10);
    vecs[13] = mk(0, 0, 1, 4,     0, 3'b010, 0, 'h14,  0,   1, 0, 2, 2'b01, 3,     0, 0, 'h10);
    vecs[14] = mk(0, 0, 1, 9,     0, 3'b010, 0, 'h18,  0,   1, 0, 2, 2'b01, 3,     0, 0, 'h10);
    vecs[15] = mk(0, 0, 0, 0,     0, 3'b010, 0, 0,     1,   1, 1, 1, 2'b01, 4,     0, 0, 'h14);
    vecs[16] = mk(0, 0, 0, 0,     0, 3'b010, 0, 0,     1,   0, 1, 0, 2'b00, 0,     0, 0, 0);
    vecs[17] = mk(0, 0, 1, 21,    1, 3'b110, 1, 'h20,  0,   1, 1, 1, 2'b01, 21,    1, 1, 'h20);
    vecs[18] = mk(0, 0, 1, 22,    0, 3'b010, 0, 'h24,  0,   1, 0, 2, 2'b01, 21,    1, 1, 'h20);
    vecs[19] = mk(0, 1, 1, 23,    0, 3'b010, 0, 'h28,  0,   0, 1, 0, 2'b10, 0,     0, 0, 0);
    vecs[20] = mk(0, 0, 0, 0,     0, 3'b010, 0, 0,     1,   0, 1, 0, 2'b00, 0,     0, 0, 0);
    vecs[21] = mk(0, 0, 1, 30,    0, 3'b010, 0, 'h30,  1,   1, 1, 1, 2'b01, 30,    0, 0, 'h30);
    vecs[22] = mk(0, 0, 0, 0,     0, 3'b010, 0, 0,     1,   0, 1, 0, 2'b00, 0,     0, 0, 0);
    vecs[23] = mk(0, 0, 1, 40,    1, 3'b110, 1, 'h44,  0,   1, 1, 1, 2'b01, 40,    1, 1, 'h44);
    vecs[24] = mk(0, 0, 1, 41,    0, 3'b010, 0, 'h48,  0,   1, 0, 2, 2'b01, 40,    1, 1, 'h44);
    vecs[25] = mk(1, 0, 1, 42,    0, 3'b010, 0, 'h4C,  0,   0, 1, 0, 2'b01, 0,     0, 0, 0);
    vecs[26] = mk(0, 0, 1, 5,     0, 3'b010, 0, 'h50,  1,   1, 1, 1, 2'b01, 5,     0, 0, 'h50);
    vecs[27] = mk(0, 0, 0, 0,     0, 3'b010, 0, 0,     1,   0, 1, 0, 2'b00, 0,     0, 0, 0);

    for (int i = 0; i < 28; i++) begin
      logic bad;
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.flush, v.iv, v.res, v.zf, v.alu, v.br, v.pcb, v.ordy);
      @(posedge clk);
      #1;
      bad = 1'b0;
      if (out_valid !== v.ov || in_ready !== v.ir || occupancy !== v.occ) bad = 1'b1;
      if (v.chk[0] && (Res_out !== v.reso || ZF_out !== v.zfo || PCBranch_out !== v.pcbo))
        bad = 1'b1;
      if ((v.chk[0] || v.chk[1]) && BranchTaken_out !== v.tko) bad = 1'b1;
      // Side fields are derived from the result value, so the skid path must carry them intact.
      if (v.chk[0] && v.ov &&
          (StoreData_out !== (v.reso ^ SDK) || WriteReg_out !== v.reso[4:0] ||
           {MemToReg_out, MemWrite_out, MemRead_out, RegWrite_out} !== v.reso[3:0]))
        bad = 1'b1;
      applied++;
      if (bad) begin
        miscompares++;
        $display("FAIL vec%0d: got ov=%b ir=%b occ=%0d res=%0d zf=%b tk=%b pcb=%h sd=%h wr=%0d; want ov=%b ir=%b occ=%0d res=%0d zf=%b tk=%b pcb=%h",
                 i, out_valid, in_ready, occupancy, Res_out, ZF_out, BranchTaken_out,
                 PCBranch_out, StoreData_out, WriteReg_out,
                 v.ov, v.ir, v.occ, v.reso, v.zfo, v.tko, v.pcbo);
      end
    end

    // Fill to FULL, then wiggle out_ready between edges: in_ready must not follow it.
    drive(0, 0, 1, 50, 0, 3'b010, 0, 'h60, 0);
    @(posedge clk); #1;
    drive(0, 0, 1, 51, 0, 3'b010, 0, 'h64, 0);
    @(posedge clk); #1;
    check("full_occ", 64'(occupancy), 64'd2);
    out_ready = 1'b1;
    #1;
    check("in_ready_no_comb", 64'(in_ready), 64'd0);
    drive(0, 0, 0, 0, 0, 3'b010, 0, 0, 0);
    @(posedge clk); #1;
    check("stall_stable", {Res_out, PCBranch_out}, {32'd50, 32'h60});
    drive(1, 0, 1, 52, 1, 3'b110, 1, 'h68, 0);
    @(posedge clk); #1;
    check("rst_full_data", {Res_out, PCBranch_out}, 64'd0);
    check("rst_full_side", {StoreData_out, WriteReg_out, RegWrite_out, MemRead_out,
                            MemWrite_out, MemToReg_out, ZF_out, BranchTaken_out}, 64'd0);
    check("rst_full_hs", {out_valid, in_ready, occupancy}, {1'b0, 1'b1, 2'd0});
    drive(0, 0, 1, 5, 0, 3'b010, 0, 'h70, 1);
    @(posedge clk); #1;
    check("post_rst_accept", {out_valid, Res_out}, {1'b1, 32'd5});
    drive(0, 0, 0, 0, 0, 3'b010, 0, 0, 1);
    @(posedge clk); #1;
    check("post_rst_drain", {out_valid, occupancy}, {1'b0, 2'd0});

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
